// File: rtl/reg_bank_reader_if.sv
// Bundle of the start/snapshot inputs and the valid/ready output stream of reg_bank_reader.
// The slave modport is the reader; the master modport is the requester/consumer side.
interface reg_bank_reader_if #(
  parameter int WIDTH   = 32,
  parameter int N_WORDS = 4
);
  logic                     start;
  logic [N_WORDS*WIDTH-1:0] in_vec;
  logic signed [WIDTH-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;
  logic                     done;

  modport master (
    output start, in_vec, out_ready,
    input  out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, in_vec, out_ready,
    output out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/reg_bank_reader.sv
// Snapshots a packed bank of signed words on start and streams them out lowest index
// first over valid/ready, followed by a one-cycle done pulse.
module reg_bank_reader #(
  parameter int WIDTH   = 32,
  parameter int N_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  reg_bank_reader_if.slave bus
);
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                   state_q, state_d;
  logic [N_WORDS*WIDTH-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          snap_d  = bus.in_vec;
          idx_d   = '0;
        end
      end
      STREAM: begin
        // out_valid is always high here, so out_ready alone completes a transfer
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.out_data  = '0;
    case (state_q)
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out_last  = (idx_q == LAST_IDX);
        for (int i = 0; i < N_WORDS; i++) begin
          if (idx_q == IDX_W'(i)) bus.out_data = $signed(snap_q[i*WIDTH +: WIDTH]);
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboarded bench for reg_bank_reader: stimulus pushes the words of each accepted snapshot,
// a negedge monitor pops them on every transfer and checks handshake/done behaviour.
module tb_reg_bank_reader;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_reader_if #(.WIDTH(W), .N_WORDS(N)) bus4 ();
  reg_bank_reader_if #(.WIDTH(W), .N_WORDS(1)) bus1 ();

  reg_bank_reader #(.WIDTH(W), .N_WORDS(N)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  reg_bank_reader #(.WIDTH(W), .N_WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   mon_en     = 1'b0;
  bit   prev_last  = 1'b0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  bit   bp_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  localparam logic [N*W-1:0] DIR_VEC  = {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000011};
  localparam logic [N*W-1:0] DIR_VEC2 = {32'h44444444, 32'hC3C3C3C3, 32'h00000002, 32'hDEADBEEF};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an accepted start yields exactly the N captured words, last flag on the final one.
  function automatic void push_vec(input logic [N*W-1:0] v);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.last = (i == N - 1);
      e.data = v[i*W +: W];
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        prev_last  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        cmp("done_after_last", {31'd0, bus4.done}, {31'd0, prev_last});
        if (prev_stall) begin
          cmp("hold_valid", {31'd0, bus4.out_valid}, 32'd1);
          cmp("hold_data", bus4.out_data, prev_data);
        end
        if (!bus4.out_valid) begin
          cmp("idle_data_zero", bus4.out_data, 32'd0);
          cmp("idle_last_zero", {31'd0, bus4.out_last}, 32'd0);
        end else begin
          cmp("busy_with_valid", {31'd0, bus4.busy}, 32'd1);
        end
        if (bus4.out_valid && bus4.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected no transfer at %0t", bus4.out_data, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("xfer_data", bus4.out_data, e.data);
            cmp("xfer_last", {31'd0, bus4.out_last}, {31'd0, e.last});
          end
        end
        if (bus4.done) done_cnt++;
        prev_last  = bus4.out_valid && bus4.out_ready && bus4.out_last;
        prev_stall = bus4.out_valid && !bus4.out_ready;
        prev_data  = bus4.out_data;
      end
    end
  end

  task automatic drive(input int c, input int mode);
    case (mode)
      1: bus4.out_ready = (c < 7) ? bp_pat[c] : 1'b1;
      2: begin
        bus4.out_ready = 1'($urandom_range(0, 1));
        bus4.start     = ($urandom_range(0, 4) == 0);
        bus4.in_vec    = {$urandom, $urandom, $urandom, $urandom};
      end
      3: begin
        bus4.out_ready = 1'b1;
        if (c == 0) begin
          bus4.start  = 1'b1;
          bus4.in_vec = '0;
        end else begin
          bus4.start = 1'b0;
        end
      end
      default: bus4.out_ready = 1'b1;
    endcase
  endtask

  task automatic run_stream(input logic [N*W-1:0] vec, input int mode);
    @(posedge clk); #1;
    bus4.in_vec    = vec;
    bus4.start     = 1'b1;
    bus4.out_ready = 1'b1;
    push_vec(vec);
    exp_done++;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    drive(0, mode);
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (bus4.done) begin
        @(posedge clk); #1;
        bus4.start     = 1'b0;
        bus4.out_ready = 1'b1;
        return;
      end
      @(posedge clk); #1;
      drive(c, mode);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL stream_timeout: got no done expected done within 200 cycles");
  endtask

  initial begin
    bus4.start = 1'b1; bus4.in_vec = DIR_VEC; bus4.out_ready = 1'b1;
    bus1.start = 1'b1; bus1.in_vec = 32'h12345678; bus1.out_ready = 1'b1;

    // Reset held two cycles with start high
    repeat (2) begin
      @(negedge clk);
      cmp("rst_valid", {31'd0, bus4.out_valid}, 32'd0);
      cmp("rst_busy", {31'd0, bus4.busy}, 32'd0);
      cmp("rst_done", {31'd0, bus4.done}, 32'd0);
      cmp("rst_last", {31'd0, bus4.out_last}, 32'd0);
      cmp("rst_data", bus4.out_data, 32'd0);
      cmp("rst1_valid", {31'd0, bus1.out_valid}, 32'd0);
      cmp("rst1_busy", {31'd0, bus1.busy}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus4.start = 1'b0; bus1.start = 1'b0;
    @(negedge clk);
    cmp("post_rst_busy", {31'd0, bus4.busy}, 32'd0);
    cmp("post_rst_valid", {31'd0, bus4.out_valid}, 32'd0);
    mon_en = 1'b1;

    // Full-rate stream, cycle-exact
    @(posedge clk); #1;
    bus4.out_ready = 1'b1; bus4.in_vec = DIR_VEC; bus4.start = 1'b1;
    push_vec(DIR_VEC);
    exp_done++;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      cmp("fr_valid", {31'd0, bus4.out_valid}, 32'd1);
      cmp("fr_data", bus4.out_data, DIR_VEC[k*W +: W]);
      cmp("fr_last", {31'd0, bus4.out_last}, {31'd0, (k == N - 1)});
      cmp("fr_busy", {31'd0, bus4.busy}, 32'd1);
      cmp("fr_done", {31'd0, bus4.done}, 32'd0);
    end
    @(negedge clk);
    cmp("fr_done_pulse", {31'd0, bus4.done}, 32'd1);
    cmp("fr_done_busy", {31'd0, bus4.busy}, 32'd1);
    cmp("fr_done_valid", {31'd0, bus4.out_valid}, 32'd0);
    @(negedge clk);
    cmp("fr_idle_busy", {31'd0, bus4.busy}, 32'd0);
    cmp("fr_idle_done", {31'd0, bus4.done}, 32'd0);

    run_stream(DIR_VEC, 1);
    run_stream(DIR_VEC, 3);
    repeat (3) begin
      @(negedge clk);
      cmp("no_restart", {31'd0, bus4.out_valid}, 32'd0);
    end

    // Reset after the second transfer
    @(posedge clk); #1;
    bus4.out_ready = 1'b1; bus4.in_vec = DIR_VEC; bus4.start = 1'b1;
    push_vec(DIR_VEC);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("mid_rst_valid", {31'd0, bus4.out_valid}, 32'd0);
    cmp("mid_rst_busy", {31'd0, bus4.busy}, 32'd0);
    cmp("mid_rst_done", {31'd0, bus4.done}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      cmp("mid_rst_no_done", {31'd0, bus4.done}, 32'd0);
    end
    run_stream(DIR_VEC2, 0);

    for (int r = 0; r < 20; r++) begin
      run_stream({$urandom, $urandom, $urandom, $urandom}, 2);
    end

    // Single-word bank
    @(posedge clk); #1;
    bus1.out_ready = 1'b1; bus1.in_vec = 32'h0000ABCD; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0; bus1.in_vec = 32'h0;
    @(negedge clk);
    cmp("n1_valid", {31'd0, bus1.out_valid}, 32'd1);
    cmp("n1_last", {31'd0, bus1.out_last}, 32'd1);
    cmp("n1_data", bus1.out_data, 32'h0000ABCD);
    cmp("n1_busy", {31'd0, bus1.busy}, 32'd1);
    cmp("n1_no_done", {31'd0, bus1.done}, 32'd0);
    @(negedge clk);
    cmp("n1_done", {31'd0, bus1.done}, 32'd1);
    cmp("n1_done_valid", {31'd0, bus1.out_valid}, 32'd0);
    cmp("n1_done_busy", {31'd0, bus1.busy}, 32'd1);
    @(negedge clk);
    cmp("n1_idle_busy", {31'd0, bus1.busy}, 32'd0);
    cmp("n1_idle_done", {31'd0, bus1.done}, 32'd0);
    cmp("n1_idle_valid", {31'd0, bus1.out_valid}, 32'd0);

    repeat (3) @(negedge clk);
    cmp("queue_drained", exp_q.size(), 32'd0);
    cmp("done_count", done_cnt, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
